// File: rtl/dm_port_arbiter_if.sv
// rtl/dm_port_arbiter_if.sv - requester and data-memory bus bundle for dm_port_arbiter
//
// Groups both requester handshakes and the single-port DM connection.
//   slave  : arbiter side (takes requests and dm_dout, drives acks, rdata and the DM controls)
//   master : requester/memory side (drives requests and dm_dout, observes the rest)
// Requester signals per port n (0 = CPU load/store, 1 = DMA/debug loader):
//   reqn, wen, addrn, wdatan, ben -> arbiter ; ackn, rdatan <- arbiter
// Memory signals: dm_addr, dm_din, dm_we -> DM ; dm_dout <- DM
interface dm_port_arbiter_if #(
    parameter int ADDR_W = 10
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [31:0]       wdata0;
    logic [31:0]       wdata1;
    logic [3:0]        be0;
    logic [3:0]        be1;
    logic              ack0;
    logic              ack1;
    logic [31:0]       rdata0;
    logic [31:0]       rdata1;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_din;
    logic              dm_we;
    logic [31:0]       dm_dout;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, be0, be1, dm_dout,
        output ack0, ack1, rdata0, rdata1, dm_addr, dm_din, dm_we
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, be0, be1, dm_dout,
        input  ack0, ack1, rdata0, rdata1, dm_addr, dm_din, dm_we
    );
endinterface

// File: rtl/dm_port_arbiter.sv
// rtl/dm_port_arbiter.sv - two-port arbiter and cycle sequencer for the single-port data memory
//
// Shares one 1024 x 32 DM (synchronous write, registered read when not writing)
// between port 0 (CPU) and port 1 (DMA/debug). Byte-enable stores are done as
// read-modify-write. This block is the only driver of the DM address, data and write enable.
// Ports:
//   clk   : system clock, rising edge
//   rstn  : asynchronous reset, active low
//   bus   : dm_port_arbiter_if.slave (both requester handshakes and the DM connection)
//   busy  : high whenever an operation is in flight (state != IDLE)
module dm_port_arbiter #(
    parameter int ADDR_W = 10,
    parameter bit RR_EN  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rstn,
    dm_port_arbiter_if.slave      bus,
    output logic                  busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_RMW_RD,
        S_MRG,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic              last_q;     // port granted most recently (round-robin pointer)
    logic              gnt_q;      // port owning the operation in flight
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic [31:0]       rdata0_q;
    logic [31:0]       rdata1_q;

    logic              grant_valid;
    logic              grant_port;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic [3:0]        sel_be;
    logic [31:0]       merged;
    logic              done_rd;

    // Arbitration: a tie goes to the port not granted last, or always to port 0
    // when round-robin is disabled.
    always_comb begin
        grant_valid = bus.req0 | bus.req1;
        if (bus.req0 && bus.req1) begin
            grant_port = RR_EN ? ~last_q : 1'b0;
        end else begin
            grant_port = bus.req1;
        end
        sel_we    = grant_port ? bus.we1    : bus.we0;
        sel_addr  = grant_port ? bus.addr1  : bus.addr0;
        sel_wdata = grant_port ? bus.wdata1 : bus.wdata0;
        sel_be    = grant_port ? bus.be1    : bus.be0;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (grant_valid) begin
                    if (!sel_we) begin
                        state_nxt = S_RD;
                    end else if (sel_be == 4'hF) begin
                        state_nxt = S_WR;
                    end else if (sel_be == 4'h0) begin
                        // nothing to store, but the requester still needs its ack
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_RMW_RD;
                    end
                end
            end
            S_RD:     state_nxt = S_DONE;
            S_WR:     state_nxt = S_DONE;
            S_RMW_RD: state_nxt = S_MRG;
            S_MRG:    state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // In MRG the DM output holds the old word read during RMW_RD.
    always_comb begin
        merged = '0;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : bus.dm_dout[8*i +: 8];
        end
    end

    assign done_rd     = (state == S_DONE) && !we_q;
    assign busy        = (state != S_IDLE);
    assign bus.dm_addr = addr_q;
    assign bus.dm_we   = (state == S_WR) || (state == S_MRG);
    assign bus.dm_din  = (state == S_WR)  ? wdata_q :
                         (state == S_MRG) ? merged  : 32'h0;
    assign bus.ack0    = (state == S_DONE) && !gnt_q;
    assign bus.ack1    = (state == S_DONE) &&  gnt_q;
    // Read data is live from the DM in the ack cycle, then held from the capture register.
    assign bus.rdata0  = (done_rd && !gnt_q) ? bus.dm_dout : rdata0_q;
    assign bus.rdata1  = (done_rd &&  gnt_q) ? bus.dm_dout : rdata1_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_IDLE;
            last_q   <= 1'b1;
            gnt_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && grant_valid) begin
                gnt_q   <= grant_port;
                last_q  <= grant_port;
                we_q    <= sel_we;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
                be_q    <= sel_be;
            end
            if (done_rd) begin
                if (gnt_q) begin
                    rdata1_q <= bus.dm_dout;
                end else begin
                    rdata0_q <= bus.dm_dout;
                end
            end
        end
    end

endmodule
